// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file index range and streams each value out over valid/ready
module reg_dump_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutIndex,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);
    typedef enum logic [1:0] {IDLE, ADDR, SEND, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              out_last_q, out_last_d;

    // state and output registers; reset clears everything and drops any dump in flight
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            last_q     <= '0;
            index_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            last_q     <= last_d;
            index_q    <= index_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            out_last_q <= out_last_d;
        end
    end

    // next state: read address settles in ADDR, word is captured into the output stage, then held until accepted
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        last_d     = last_q;
        index_d    = index_q;
        data_d     = data_q;
        valid_d    = valid_q;
        out_last_d = out_last_q;
        if (Abort && state_q != IDLE) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            out_last_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        rd_addr_d = FirstReg;
                        last_d    = LastReg;
                        state_d   = ADDR;
                    end
                end
                ADDR: begin
                    data_d     = RdData;
                    index_d    = rd_addr_q;
                    valid_d    = 1'b1;
                    out_last_d = rd_addr_q == last_q;
                    state_d    = SEND;
                end
                SEND: begin
                    if (OutReady) begin
                        valid_d = 1'b0;
                        if (out_last_q) begin
                            out_last_d = 1'b0;
                            state_d    = FIN;
                        end else begin
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            state_d   = ADDR;
                        end
                    end
                end
                FIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign RdAddr   = rd_addr_q;
    assign OutValid = valid_q;
    assign OutData  = data_q;
    assign OutIndex = index_q;
    assign OutLast  = out_last_q;
    assign Busy     = state_q != IDLE;
    assign Done     = state_q == FIN;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: randomized dumps checked against an index-list model of the dump order and timing
module tb_reg_dump_reader;
    logic        Clk = 1'b0;
    logic        Rst, Start, Abort, OutReady;
    logic [3:0]  FirstReg, LastReg, RdAddr, OutIndex;
    logic [15:0] RdData, OutData;
    logic        OutValid, OutLast, Busy, Done;
    logic [15:0] regs [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    reg_dump_reader #(.DATA_W(16), .ADDR_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
        .FirstReg(FirstReg), .LastReg(LastReg), .RdAddr(RdAddr), .RdData(RdData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutIndex(OutIndex),
        .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    assign RdData = regs[RdAddr];

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic test_reset;
        Rst = 1; Start = 1; Abort = 1; OutReady = 1; FirstReg = 4'd7; LastReg = 4'd9;
        repeat (2) @(negedge Clk);
        n_checks++; if (RdAddr !== 4'd0) begin n_fail++; $display("FAIL reset_rdaddr: got %0d expected 0", RdAddr); end
        n_checks++; if (OutData !== 16'd0) begin n_fail++; $display("FAIL reset_outdata: got %h expected 0", OutData); end
        n_checks++; if (OutIndex !== 4'd0) begin n_fail++; $display("FAIL reset_outindex: got %0d expected 0", OutIndex); end
        n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
        n_checks++; if (OutLast !== 1'b0) begin n_fail++; $display("FAIL reset_outlast: got %b expected 0", OutLast); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
        Rst = 0; Start = 0; Abort = 0; OutReady = 0;
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", Busy); end
    endtask

    // stall_pct: chance of OutReady=0; hold: initial valid cycles with OutReady forced low; pulse: spam Start while busy
    task automatic test_dump(input string name, input logic [3:0] f, input logic [3:0] l,
                             input int stall_pct, input int hold, input bit pulse);
        int          exp_idx[$];
        int          obs_idx[$];
        logic [15:0] obs_dat[$];
        logic        obs_last[$];
        int          vcyc[$];
        int          hcyc[$];
        int          i, start_cyc, done_cyc, held, stable_bad, n;
        logic        pv, pr, pl, busy_after, done_after;
        logic [15:0] pd;
        logic [3:0]  pi;
        bit          timed_out;
        i = int'(f);
        forever begin
            exp_idx.push_back(i);
            if (i == int'(l)) break;
            i = (i + 1) % 16;
        end
        @(negedge Clk);
        FirstReg = f; LastReg = l; Start = 1; OutReady = 0; start_cyc = cyc;
        pv = 0; pr = 0; pd = '0; pi = '0; pl = 0;
        held = 0; stable_bad = 0; done_cyc = -1; timed_out = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (Done) begin
                done_cyc = cyc; timed_out = 0;
                break;
            end
            if (OutValid && !pv) vcyc.push_back(cyc);
            if (OutValid && pv && !pr && {OutData, OutIndex, OutLast} !== {pd, pi, pl}) stable_bad++;
            OutReady = (held < hold) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            if (OutValid && !OutReady) held++;
            if (OutValid && OutReady) begin
                obs_idx.push_back(int'(OutIndex)); obs_dat.push_back(OutData);
                obs_last.push_back(OutLast); hcyc.push_back(cyc);
            end
            pv = OutValid; pr = OutReady; pd = OutData; pi = OutIndex; pl = OutLast;
            Start = pulse ? 1'($urandom_range(1)) : 1'b0;
            FirstReg = 4'($urandom); LastReg = 4'($urandom);
        end
        Start = 0; OutReady = 0;
        @(negedge Clk);
        busy_after = Busy; done_after = Done;
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL %s_done_seen: got none expected Done within 400 cycles", name); end
        n_checks++; if (obs_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL %s_word_count: got %0d expected %0d", name, obs_idx.size(), exp_idx.size()); end
        n_checks++; if (vcyc.size() != exp_idx.size()) begin n_fail++; $display("FAIL %s_valid_count: got %0d expected %0d", name, vcyc.size(), exp_idx.size()); end
        n = (obs_idx.size() < exp_idx.size()) ? obs_idx.size() : exp_idx.size();
        if (vcyc.size() < n) n = vcyc.size();
        for (int k = 0; k < n; k++) begin
            n_checks++; if (obs_idx[k] != exp_idx[k]) begin n_fail++; $display("FAIL %s_index[%0d]: got %0d expected %0d", name, k, obs_idx[k], exp_idx[k]); end
            n_checks++; if (obs_dat[k] !== regs[exp_idx[k]]) begin n_fail++; $display("FAIL %s_data[%0d]: got %h expected %h", name, k, obs_dat[k], regs[exp_idx[k]]); end
            n_checks++; if (obs_last[k] !== (k == exp_idx.size() - 1)) begin n_fail++; $display("FAIL %s_last[%0d]: got %b expected %b", name, k, obs_last[k], k == exp_idx.size() - 1); end
            n_checks++; if (vcyc[k] != ((k == 0) ? start_cyc + 2 : hcyc[k-1] + 2)) begin n_fail++; $display("FAIL %s_latency[%0d]: got cycle %0d expected %0d", name, k, vcyc[k], (k == 0) ? start_cyc + 2 : hcyc[k-1] + 2); end
        end
        if (hold > 0 && stall_pct == 0 && hcyc.size() > 0 && vcyc.size() > 0) begin
            n_checks++; if (hcyc[0] != vcyc[0] + hold) begin n_fail++; $display("FAIL %s_hold: got handshake cycle %0d expected %0d", name, hcyc[0], vcyc[0] + hold); end
        end
        if (hcyc.size() > 0 && !timed_out) begin
            n_checks++; if (done_cyc != hcyc[hcyc.size()-1] + 1) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, hcyc[hcyc.size()-1] + 1); end
        end
        n_checks++; if (stable_bad != 0) begin n_fail++; $display("FAIL %s_stable: got %0d changes expected 0", name, stable_bad); end
        n_checks++; if ({busy_after, done_after} !== 2'b00) begin n_fail++; $display("FAIL %s_idle_after: got busy/done %b%b expected 00", name, busy_after, done_after); end
    endtask

    task automatic test_abort;
        int seen, bad;
        @(negedge Clk);
        FirstReg = 4'd0; LastReg = 4'd7; OutReady = 1; Start = 1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(negedge Clk);
            Start = 0;
            if (OutValid) seen++;
        end
        n_checks++; if (seen != 2 || OutIndex !== 4'd1) begin n_fail++; $display("FAIL abort_second_word: got seen=%0d index=%0d expected seen=2 index=1", seen, OutIndex); end
        Abort = 1;
        @(negedge Clk);
        Abort = 0;
        n_checks++; if ({OutValid, OutLast, Busy, Done} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got valid/last/busy/done %b expected 0000", {OutValid, OutLast, Busy, Done}); end
        bad = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done || OutValid || Busy) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_more: got %0d active cycles expected 0", bad); end
        OutReady = 0;
    endtask

    task automatic test_abort_idle;
        bit got;
        @(negedge Clk);
        Abort = 1; Start = 0;
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_noeffect: got busy %b expected 0", Busy); end
        FirstReg = 4'd9; LastReg = 4'd9; Start = 1;
        @(negedge Clk);
        Start = 0; Abort = 0;
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_start_wins: got busy %b expected 1", Busy); end
        OutReady = 1; got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (Done) begin got = 1; break; end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL abort_start_done: got no Done expected Done within 10 cycles"); end
        OutReady = 0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge Clk);
        FirstReg = 4'd3; LastReg = 4'd9; OutReady = 0; Start = 1;
        @(negedge Clk);
        Start = 0;
        for (int k = 0; k < 10 && !OutValid; k++) @(negedge Clk);
        n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_send: got valid %b expected 1", OutValid); end
        Rst = 1;
        @(negedge Clk);
        Rst = 0;
        n_checks++; if ({RdAddr, OutData, OutIndex, OutValid, OutLast, Busy, Done} !== 28'd0) begin n_fail++; $display("FAIL rstmid_clear: got %h expected 0", {RdAddr, OutData, OutIndex, OutValid, OutLast, Busy, Done}); end
        bad = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Done || Busy) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        test_reset;
        test_dump("basic", 4'd2, 4'd4, 0, 0, 1'b0);
        test_dump("wrap", 4'd14, 4'd1, 0, 0, 1'b0);
        test_dump("single_stall", 4'd5, 4'd5, 0, 6, 1'b0);
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        test_dump("start_ignored", 4'd3, 4'd8, 30, 0, 1'b1);
        test_abort;
        test_abort_idle;
        test_reset_mid;
        test_dump("after_reset", 4'd6, 4'd8, 20, 0, 1'b0);
        repeat (8) begin
            for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
            test_dump("random", 4'($urandom), 4'($urandom), $urandom_range(60), 0, 1'($urandom_range(1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
